// File: rtl/spi_globals_pkg.sv
// -----------------------------------------------------------------------------
// spi_globals_pkg
// Shared SPI types and constants.
//   spi_mode_e       : SPI mode encoded as {cpol, cpha}.
//   sampler_state_e  : frame sampler FSM states.
//   MIN_OVERSAMPLE   : minimum pclk/sclk frequency ratio.
//   make_mode()      : packs cpol/cpha into an spi_mode_e.
//   samples_on_fall(): 1 when the mode samples data on the falling sclk edge.
// -----------------------------------------------------------------------------
package spi_globals_pkg;

  // Synchroniser depth plus edge detection needs a few pclk cycles per sclk
  // phase. Below this ratio edges can be merged or lost.
  localparam int MIN_OVERSAMPLE = 4;

  typedef enum logic [1:0] {
    MODE0 = 2'b00,  // cpol=0, cpha=0
    MODE1 = 2'b01,  // cpol=0, cpha=1
    MODE2 = 2'b10,  // cpol=1, cpha=0
    MODE3 = 2'b11   // cpol=1, cpha=1
  } spi_mode_e;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } sampler_state_e;

  function automatic spi_mode_e make_mode(input logic cpol, input logic cpha);
    return spi_mode_e'({cpol, cpha});
  endfunction

  // Modes 0 and 3 sample on the rising edge, modes 1 and 2 on the falling one.
  function automatic logic samples_on_fall(input spi_mode_e mode);
    return mode[1] ^ mode[0];
  endfunction

endpackage

// File: rtl/spi_bit_sync.sv
// -----------------------------------------------------------------------------
// spi_bit_sync
// Multi-flop synchroniser for one asynchronous bus line followed by a history
// flop used for edge detection.
// Ports:
//   clk    : system clock
//   rst_n  : synchronous reset, active-low
//   init   : value every flop loads while in reset (the line's idle level)
//   din    : asynchronous input
//   level  : synchronised level (output of the last synchroniser stage)
//   rise   : one-cycle pulse on a synchronised 0->1 transition
//   fall   : one-cycle pulse on a synchronised 1->0 transition
// Parameters:
//   SYNC_STAGES : synchroniser depth (legal 2..3)
// -----------------------------------------------------------------------------
module spi_bit_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic init,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] stages;
  logic                   hist;

  // Loading the idle level at reset keeps the first cycles after reset from
  // looking like an edge on the line.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stages <= {SYNC_STAGES{init}};
      hist   <= init;
    end else begin
      // NOTE: non-blocking assignments make every stage take the value its
      // predecessor held before the edge, which is what builds a shift chain.
      stages <= {stages[SYNC_STAGES-2:0], din};
      hist   <= stages[SYNC_STAGES-1];
    end
  end

  assign level = stages[SYNC_STAGES-1];
  assign rise  = level & ~hist;
  assign fall  = ~level & hist;

endmodule

// File: rtl/spi_slave_frame_sampler.sv
// -----------------------------------------------------------------------------
// spi_slave_frame_sampler
// Oversampling SPI capture stage. Synchronises sclk/cs_n/mosi/miso to pclk,
// deserialises both data directions in the configured SPI mode and presents
// each completed word pair on a valid/ready interface with a single holding
// register.
// Ports:
//   pclk          : system clock, at least MIN_OVERSAMPLE x sclk
//   areset        : synchronous reset, active-low
//   cfg_cpol      : sclk idle level            (latched at frame start)
//   cfg_cpha      : 0 leading / 1 trailing edge sampling (latched at frame start)
//   cfg_lsb_first : bit order                  (latched at frame start)
//   sclk, cs_n, mosi, miso : asynchronous SPI bus lines
//   frm_valid     : captured word pair available
//   frm_ready     : consumer accepts the word pair
//   frm_mosi      : captured MOSI word
//   frm_miso      : captured MISO word
//   frm_err       : one-cycle pulse, cs_n deasserted mid-word
//   frm_ovf       : one-cycle pulse, completed word dropped (holding reg full)
//   busy          : high while a frame is active
// Parameters:
//   DATA_WIDTH  : bits per SPI word (legal 4..32)
//   SYNC_STAGES : synchroniser depth (legal 2..3)
// -----------------------------------------------------------------------------
module spi_slave_frame_sampler
  import spi_globals_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  pclk,
  input  logic                  areset,
  input  logic                  cfg_cpol,
  input  logic                  cfg_cpha,
  input  logic                  cfg_lsb_first,
  input  logic                  sclk,
  input  logic                  cs_n,
  input  logic                  mosi,
  input  logic                  miso,
  output logic                  frm_valid,
  input  logic                  frm_ready,
  output logic [DATA_WIDTH-1:0] frm_mosi,
  output logic [DATA_WIDTH-1:0] frm_miso,
  output logic                  frm_err,
  output logic                  frm_ovf,
  output logic                  busy
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_WIDTH);

  // ---------------------------------------------------------------------------
  // Input synchronisers. All four lines use the same depth, so data and sclk
  // edges arrive in the same relative order they had on the bus.
  // ---------------------------------------------------------------------------
  logic sclk_rise, sclk_fall;
  logic cs_rise, cs_fall;
  logic mosi_s, miso_s;
  logic sclk_level_unused, cs_level_unused;
  logic [3:0] data_edges_unused;

  spi_bit_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk   (pclk),
    .rst_n (areset),
    .init  (cfg_cpol),
    .din   (sclk),
    .level (sclk_level_unused),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  spi_bit_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
    .clk   (pclk),
    .rst_n (areset),
    .init  (1'b1),
    .din   (cs_n),
    .level (cs_level_unused),
    .rise  (cs_rise),
    .fall  (cs_fall)
  );

  spi_bit_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk   (pclk),
    .rst_n (areset),
    .init  (1'b0),
    .din   (mosi),
    .level (mosi_s),
    .rise  (data_edges_unused[0]),
    .fall  (data_edges_unused[1])
  );

  spi_bit_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_miso (
    .clk   (pclk),
    .rst_n (areset),
    .init  (1'b0),
    .din   (miso),
    .level (miso_s),
    .rise  (data_edges_unused[2]),
    .fall  (data_edges_unused[3])
  );

  // ---------------------------------------------------------------------------
  // Frame state
  // ---------------------------------------------------------------------------
  sampler_state_e        state;
  spi_mode_e             mode_q;
  logic                  lsb_q;
  logic [CNT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-1:0] sr_mosi;
  logic [DATA_WIDTH-1:0] sr_miso;

  // ---------------------------------------------------------------------------
  // Next-value logic for the shift registers and bit counter
  // ---------------------------------------------------------------------------
  logic                  sample;
  logic                  word_done;
  logic [CNT_W-1:0]      cnt_inc;
  logic [CNT_W-1:0]      cnt_next;
  logic [DATA_WIDTH-1:0] mosi_shift;
  logic [DATA_WIDTH-1:0] miso_shift;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    sample     = 1'b0;
    word_done  = 1'b0;
    cnt_inc    = bit_cnt + 1'b1;
    cnt_next   = bit_cnt;
    mosi_shift = sr_mosi;
    miso_shift = sr_miso;

    if (state == ACTIVE) begin
      // The non-sampling edge of sclk is simply ignored.
      sample = samples_on_fall(mode_q) ? sclk_fall : sclk_rise;
    end

    if (sample) begin
      if (lsb_q) begin
        mosi_shift = {mosi_s, sr_mosi[DATA_WIDTH-1:1]};
        miso_shift = {miso_s, sr_miso[DATA_WIDTH-1:1]};
      end else begin
        mosi_shift = {sr_mosi[DATA_WIDTH-2:0], mosi_s};
        miso_shift = {sr_miso[DATA_WIDTH-2:0], miso_s};
      end
      word_done = (cnt_inc == CNT_FULL);
      cnt_next  = word_done ? '0 : cnt_inc;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM, mode latch, deserialiser and output holding register
  // ---------------------------------------------------------------------------
  always_ff @(posedge pclk) begin
    if (!areset) begin
      state     <= IDLE;
      mode_q    <= MODE0;
      lsb_q     <= 1'b0;
      bit_cnt   <= '0;
      sr_mosi   <= '0;
      sr_miso   <= '0;
      frm_valid <= 1'b0;
      frm_mosi  <= '0;
      frm_miso  <= '0;
      frm_err   <= 1'b0;
      frm_ovf   <= 1'b0;
    end else begin
      frm_err <= 1'b0;
      frm_ovf <= 1'b0;

      // Handshake retires the held word; a load below in the same cycle
      // overrides this and keeps frm_valid high with no bubble.
      if (frm_valid && frm_ready) begin
        frm_valid <= 1'b0;
      end

      unique case (state)
        IDLE: begin
          if (cs_fall) begin
            state   <= ACTIVE;
            bit_cnt <= '0;
            mode_q  <= make_mode(cfg_cpol, cfg_cpha);
            lsb_q   <= cfg_lsb_first;
          end
        end

        ACTIVE: begin
          if (sample) begin
            sr_mosi <= mosi_shift;
            sr_miso <= miso_shift;
            bit_cnt <= cnt_next;
          end

          if (word_done) begin
            if (!frm_valid || frm_ready) begin
              frm_valid <= 1'b1;
              frm_mosi  <= mosi_shift;
              frm_miso  <= miso_shift;
            end else begin
              // Holding register still owned by the consumer: keep the old
              // word and report the loss of the new one.
              frm_ovf <= 1'b1;
            end
          end

          // cnt_next already includes a sample taken this cycle, so a final
          // bit arriving together with cs_n rising still completes the word.
          if (cs_rise) begin
            state   <= IDLE;
            bit_cnt <= '0;
            if (cnt_next != '0) begin
              frm_err <= 1'b1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == ACTIVE);

endmodule
